// File: rtl/tt_um_addon_serial.sv
// Bit-serial adder/subtractor/accumulator: byte-wide operand loads, one bit per
// clock through a full adder with a carry flop, byte-wide result readback.
module tt_um_addon_serial #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int unsigned NB = WIDTH / 8;
    localparam int unsigned PW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] r_q;
    logic             c_q;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    rd_ptr;
    logic             carry_q;
    logic             ovf_q;
    logic             mode_sub;
    logic             mode_acc;

    logic load_a, load_b, start, rd_next;
    logic a0, b0, s_bit, c_nxt;

    assign load_a  = uio_in[0];
    assign load_b  = uio_in[1];
    assign start   = uio_in[2];
    assign rd_next = uio_in[3];

    // One full-adder slice on the current LSBs
    assign a0    = a_q[0];
    assign b0    = b_q[0];
    assign s_bit = a0 ^ b0 ^ c_q;
    assign c_nxt = (a0 & b0) | (a0 & c_q) | (b0 & c_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            r_q      <= '0;
            c_q      <= 1'b0;
            cnt      <= '0;
            rd_ptr   <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            mode_sub <= 1'b0;
            mode_acc <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mode_acc <= ui_in[0];
                        mode_sub <= ui_in[1];
                        if (ui_in[0]) a_q <= r_q;
                        if (ui_in[1]) begin
                            b_q <= ~b_q;
                            c_q <= 1'b1;
                        end else begin
                            c_q <= 1'b0;
                        end
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        if (load_a) a_q <= {ui_in, a_q[WIDTH-1:8]};
                        if (load_b) b_q <= {ui_in, b_q[WIDTH-1:8]};
                    end
                    if (rd_next) begin
                        rd_ptr <= (rd_ptr == PW'(NB - 1)) ? '0 : rd_ptr + PW'(1);
                    end
                end
                RUN: begin
                    c_q <= c_nxt;
                    a_q <= a_q >> 1;
                    b_q <= b_q >> 1;
                    s_q <= {s_bit, s_q[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                    // Last bit: a0/b0 are the operand MSBs, s_bit the sum MSB
                    if (cnt == CW'(WIDTH - 1)) begin
                        r_q     <= {s_bit, s_q[WIDTH-1:1]};
                        carry_q <= c_nxt;
                        ovf_q   <= (a0 == b0) && (s_bit != a0);
                        rd_ptr  <= '0;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign uo_out  = 8'(r_q >> {rd_ptr, 3'b000});
    assign uio_out = {state == DONE, state == RUN, ovf_q, carry_q, 4'b0000};
    assign uio_oe  = 8'hF0;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:4], s_q[0], mode_acc, mode_sub};

endmodule

// File: tb/tb_tt_um_addon_serial.sv
// Scoreboard bench for tt_um_addon_serial at WIDTH=16: expected results are
// queued at start and compared when done rises.
module tb_tt_um_addon_serial;

    localparam int unsigned W  = 16;
    localparam int unsigned NB = W / 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } exp_t;

    exp_t         sb[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] last_r = '0;

    tt_um_addon_serial #(.WIDTH(W)) dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   t;
        bb  = sub ? ~b : b;
        t   = {1'b0, a} + {1'b0, bb} + (W+1)'(sub);
        e.r = t[W-1:0];
        e.c = t[W];
        e.v = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic load_op(input bit which_b, input logic [W-1:0] v);
        for (int i = 0; i < NB; i++) begin
            ui_in  = v[8*i +: 8];
            uio_in = which_b ? 8'h02 : 8'h01;
            tick();
        end
        uio_in = 8'h00;
        ui_in  = 8'h00;
    endtask

    // Start, count busy cycles, then pop the scoreboard and read R back bytewise
    task automatic run_op(input string tag, input logic [7:0] mode, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit inject);
        exp_t         e;
        exp_t         got;
        int           n;
        logic [W-1:0] rd;
        sb.push_back(model(mode[0] ? last_r : a, b, mode[1]));
        ui_in  = mode;
        uio_in = 8'h04;
        tick();
        uio_in = 8'h00;
        ui_in  = 8'h00;
        n = 0;
        while (uio_out[6] && n < 100) begin
            n++;
            if (inject && n >= 3 && n <= 5) begin
                uio_in = 8'h0F;
                ui_in  = 8'hFF;
            end else begin
                uio_in = 8'h00;
                ui_in  = 8'h00;
            end
            tick();
        end
        uio_in = 8'h00;
        check({tag, " busy_cycles"}, 64'(n), 64'(W));
        check({tag, " done"}, 64'(uio_out[7]), 64'd1);
        if (sb.size() == 0) begin
            check({tag, " sb_empty"}, 64'd1, 64'd0);
        end else begin
            e     = sb.pop_front();
            got.c = uio_out[4];
            got.v = uio_out[5];
            rd    = '0;
            for (int i = 0; i < NB; i++) begin
                rd[8*i +: 8] = uo_out;
                uio_in = 8'h08;
                tick();
                uio_in = 8'h00;
            end
            got.r = rd;
            check({tag, " R"}, 64'(got.r), 64'(e.r));
            check({tag, " carry"}, 64'(got.c), 64'(e.c));
            check({tag, " ovf"}, 64'(got.v), 64'(e.v));
            check({tag, " wrap"}, 64'(uo_out), 64'(e.r[7:0]));
            last_r = e.r;
        end
    endtask

    task automatic op(input string tag, input logic [7:0] mode, input logic [W-1:0] a,
                      input logic [W-1:0] b);
        load_op(1'b0, a);
        load_op(1'b1, b);
        run_op(tag, mode, a, b, 1'b0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        rst_n  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst uo_out", 64'(uo_out), 64'h00);
        check("rst uio_out", 64'(uio_out), 64'h00);
        check("uio_oe", 64'(uio_oe), 64'hF0);

        // Byte readback order: 0x24 then 0x22, wrapping back to 0x24
        op("add", 8'h00, 16'h1234, 16'h0FF0);
        op("carry", 8'h00, 16'hFFFF, 16'h0001);
        op("ovf", 8'h00, 16'h7FFF, 16'h0001);
        op("sub_neg", 8'h02, 16'h0005, 16'h0007);
        op("sub_pos", 8'h02, 16'h0007, 16'h0005);
        op("sub_ovf", 8'h02, 16'h8000, 16'h0001);

        op("acc0", 8'h00, 16'h0001, 16'h0002);
        load_op(1'b1, 16'h0002);
        run_op("acc1", 8'h01, 16'h0000, 16'h0002, 1'b0);

        // Loads, rd_next and a second start inside RUN must have no effect
        load_op(1'b0, 16'h1111);
        load_op(1'b1, 16'h2222);
        run_op("ignore", 8'h00, 16'h1111, 16'h2222, 1'b1);

        for (int k = 0; k < 6; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            op("rand", (k % 2 == 1) ? 8'h02 : 8'h00, ra, rb);
        end

        // Reset in the middle of a run drops everything
        load_op(1'b0, 16'h1234);
        load_op(1'b1, 16'h1111);
        uio_in = 8'h04;
        tick();
        uio_in = 8'h00;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst busy", 64'(uio_out[6]), 64'd0);
        check("midrst done", 64'(uio_out[7]), 64'd0);
        check("midrst uo_out", 64'(uo_out), 64'h00);
        check("midrst uio_out", 64'(uio_out), 64'h00);
        repeat (40) tick();
        check("midrst later uio_out", 64'(uio_out), 64'h00);
        check("midrst later uo_out", 64'(uo_out), 64'h00);
        check("sb drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tt_um_addon_serial.md
# tt_um_addon_serial

Parametrised bit-serial adder/subtractor/accumulator. It is the Tiny Tapeout user-project top that succeeds the single-bit combinational half adder in this project. Operands of WIDTH bits are loaded a byte at a time over the dedicated inputs. A full adder with a carry flop then processes one bit per clock, LSB first. The result is read back a byte at a time, together with carry, overflow, busy and done flags.

## Interface
- WIDTH, 16, operand/result width in bits; multiple of 8, range 8..64; NB = WIDTH/8 bytes
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low; all state cleared on any rising clk edge with rst_n=0
- ena  in  1  always 1 when powered; ignored
- ui_in  in  8  data byte for loads; at start, ui_in[0]=acc mode, ui_in[1]=sub mode
- uio_in  in  8  [0] load_a, [1] load_b, [2] start, [3] rd_next; [7:4] ignored
- uo_out  out  8  result byte R[8*rd_ptr +: 8]
- uio_out  out  8  [4] carry, [5] overflow, [6] busy, [7] done; [3:0]=0
- uio_oe  out  8  constant 8'hF0

## Operation
- All strobes are level-sampled: every clk edge with the bit high counts as one event.
- Registers:
  - A, B: WIDTH-bit operands.
  - S: WIDTH-bit shift register.
  - R: WIDTH-bit result.
  - c: carry flop.
  - cnt: bit counter.
  - rd_ptr: byte pointer, log2(NB) bits.
  - Flags: carry, overflow.
  - mode_sub, mode_acc.
- Load, allowed only in IDLE or DONE:
  - load_a: A <= {ui_in, A[WIDTH-1:8]}, so the first byte loaded ends up as the LSB after NB loads.
  - load_b does the same into B.
  - load_a and load_b in the same cycle load both registers from the same byte.
- Start, allowed only in IDLE or DONE:
  - Latches mode_acc=ui_in[0] and mode_sub=ui_in[1].
  - If mode_acc, A <= R.
  - If mode_sub, B <= ~B and c <= 1; otherwise c <= 0.
  - cnt <= 0; state goes to RUN.
  - Load strobes in the start cycle are ignored; start uses the pre-cycle A/B.
- RUN, each cycle:
  - s = A[0]^B[0]^c
  - c <= majority(A[0], B[0], c)
  - A and B shift right by 1
  - S <= {s, S[WIDTH-1:1]}
  - cnt++
  - On the edge processing bit WIDTH-1:
    - R <= final sum
    - carry <= carry out
    - overflow <= (A_msb == B'_msb) && (sum_msb != A_msb), where B' is B after optional inversion
    - rd_ptr <= 0
    - state goes to DONE
- In RUN, load_a, load_b, start and rd_next are all ignored.
- In sub mode, carry = 1 means no borrow (A >= B unsigned).
- rd_next, in IDLE or DONE: rd_ptr <= (rd_ptr == NB-1) ? 0 : rd_ptr+1. It wraps.
- FSM transitions:
  - IDLE -> RUN on start.
  - RUN -> DONE after WIDTH cycles.
  - DONE -> RUN on start.
  - There is no return to IDLE except through reset.
- After a run, A and B hold shifted-out values (zero). Both operands must be reloaded before the next non-acc start; only B needs reloading before an acc start.

## Timing
- Reset values: A=B=S=R=0, c=0, cnt=0, rd_ptr=0, carry=overflow=0, state=IDLE. This gives uo_out=0x00 and uio_out=0x00.
- Start sampled at edge k gives:
  - busy=1 after edge k through edge k+WIDTH-1.
  - done=1 and flags/R valid after edge k+WIDTH.
  - Latency is WIDTH clock cycles.
- done=1 only in DONE. It clears on the edge that samples the next start, or on reset.
- uo_out is combinational from R and rd_ptr, and updates the cycle after rd_next.
- Reset mid-RUN aborts the operation. Every register returns to its reset value on that edge, and no partial result reaches R.

## Test plan
- Add, WIDTH=16:
  - Stimulus: load_a 0x34, 0x12; load_b 0xF0, 0x0F; start with ui_in=0x00.
  - Response: busy=1 for 16 cycles, then done=1, uo_out=0x24, carry=0, overflow=0.
  - After rd_next: uo_out=0x22.
  - After a second rd_next: uo_out wraps to 0x24.
- Carry/overflow:
  - 0xFFFF+0x0001 gives R=0x0000, carry=1, overflow=0.
  - 0x7FFF+0x0001 gives R=0x8000, carry=0, overflow=1.
- Subtract: 0x0005-0x0007 with ui_in=0x02 at start gives R=0xFFFE, carry=0, overflow=0.
  - 0x0007-0x0005 gives R=0x0002, carry=1.
- Accumulate:
  - First run 0x0001+0x0002 gives R=0x0003.
  - Then load_b 0x02, 0x00 and start with ui_in=0x01: R=0x0005, with A not reloaded.
- Ignored strobes:
  - load_a, load_b and rd_next pulsed during RUN leave A, B and rd_ptr unaffected.
  - A second start in RUN does not restart the operation; done still occurs exactly 16 cycles after the first start.
- Reset mid-run: rst_n=0 for 1 cycle at RUN cycle 5 gives busy=0, done=0, uo_out=0x00 and uio_out=0x00 on the next cycle. No result is produced afterwards without a new start.
